amiga_clk_mon: RTL and testbench



---
 rtl/amiga_clk_mon.sv | 191 +++++++++++++++++++
 tb/tb_amiga_clk_mon.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/amiga_clk_mon.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : amiga_clk_mon                                              |
// | Description : Cadence checker for the Amiga clk7_en / clk7n_en / c1 / c3 |
// |               enables and the E-clock phase-0 level, on the 28 MHz clock.|
// |               Locks onto the 7 MHz period, then reports deviations as    |
// |               sticky flags, a saturating counter and a one-cycle strobe. |
// |               Optional E-clock check: define MINIMIG_CLK_MON_ECLK_EN.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module amiga_clk_mon #(
  parameter int LOCK_PERIODS = 4,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk_28,
  input  logic                 rst_n,
  input  logic                 clk7_en,
  input  logic                 clk7n_en,
  input  logic                 c1,
  input  logic                 c3,
  input  logic                 eclk0,
  input  logic                 clr,
  output logic                 mon_locked,
  output logic                 err_stb,
  output logic [3:0]           err_flags,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           phase
);

  typedef enum logic [0:0] {
    ST_ACQ    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   seen_q, seen_d;
  logic [3:0]             good_q, good_d;
  logic                   mon_locked_q, mon_locked_d;
  logic                   err_stb_q, err_stb_d;
  logic [3:0]             err_flags_q, err_flags_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [1:0]             c13_exp;
  logic [3:0]             e_vec;
  logic                   err;
  logic                   e3;
  logic                   eseen_ok;
  logic                   report;

`ifdef MINIMIG_CLK_MON_ECLK_EN
  logic [5:0]             ecnt_q, ecnt_d;
  logic                   eclk0_prev_q;
  logic                   eseen_q, eseen_d;
  logic                   eclk0_rise;

  // E-clock position (0..39), pulled back to 1 on each rising eclk0 so a
  // healthy waveform always has ecnt==0 on the rising cycle.
  always_comb begin
    eclk0_rise = eclk0 & ~eclk0_prev_q;
    ecnt_d     = (ecnt_q == 6'd39) ? 6'd0 : ecnt_q + 6'd1;
    if (eclk0_rise) begin
      ecnt_d = 6'd1;
    end
    eseen_d  = eseen_q | eclk0_rise;
    e3       = eseen_q & (eclk0 != (ecnt_q < 6'd4));
    eseen_ok = eseen_q;
  end

  // E-clock tracker registers
  always_ff @(posedge clk_28 or negedge rst_n) begin
    if (!rst_n) begin
      ecnt_q       <= 6'd0;
      eclk0_prev_q <= 1'b0;
      eseen_q      <= 1'b0;
    end else begin
      ecnt_q       <= ecnt_d;
      eclk0_prev_q <= eclk0;
      eseen_q      <= eseen_d;
    end
  end
`else
  // E-clock input is deliberately unobserved in this build.
  logic unused_eclk0;
  assign unused_eclk0 = eclk0;
  assign e3           = 1'b0;
  assign eseen_ok     = 1'b1;
`endif

  // Phase counter: resynchronises to 1 after every clk7_en, free-runs otherwise
  always_comb begin
    cnt_d  = clk7_en ? 2'd1 : cnt_q + 2'd1;
    seen_d = seen_q | clk7_en;
  end

  // Compare the inputs against the waveform expected at the current phase
  always_comb begin
    c13_exp = 2'b00;
    case (cnt_q)
      2'd0:    c13_exp = 2'b00;
      2'd1:    c13_exp = 2'b10;
      2'd2:    c13_exp = 2'b11;
      default: c13_exp = 2'b01;
    endcase
    e_vec = 4'b0000;
    if (seen_q) begin
      e_vec[0] = clk7_en  != (cnt_q == 2'd0);
      e_vec[1] = clk7n_en != (cnt_q == 2'd2);
      e_vec[2] = {c1, c3} != c13_exp;
      e_vec[3] = e3;
    end
    err = |e_vec;
  end

  // Lock FSM: count clean 7 MHz periods in ACQ, drop back on any error
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      ST_ACQ: begin
        if (err) begin
          good_d = 4'd0;
        end else if (clk7_en && seen_q && (good_q != 4'hF)) begin
          good_d = good_q + 4'd1;
        end
        if (!err && eseen_ok && (good_d >= 4'(LOCK_PERIODS))) begin
          state_d = ST_LOCKED;
          good_d  = 4'd0;
        end
      end
      default: begin
        good_d = 4'd0;
        if (err) begin
          state_d = ST_ACQ;
        end
      end
    endcase
    mon_locked_d = (state_d == ST_LOCKED);
  end

  // Error reporting while locked; a reported error takes priority over clr
  always_comb begin
    report      = (state_q == ST_LOCKED) && err;
    err_stb_d   = report;
    err_flags_d = err_flags_q;
    err_cnt_d   = err_cnt_q;
    if (report) begin
      if (clr) begin
        err_flags_d = e_vec;
        err_cnt_d   = ERR_CNT_W'(1);
      end else begin
        err_flags_d = err_flags_q | e_vec;
        err_cnt_d   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
      end
    end else if (clr) begin
      err_flags_d = 4'b0000;
      err_cnt_d   = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk_28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ACQ;
      cnt_q        <= 2'd0;
      seen_q       <= 1'b0;
      good_q       <= 4'd0;
      mon_locked_q <= 1'b0;
      err_stb_q    <= 1'b0;
      err_flags_q  <= 4'b0000;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      good_q       <= good_d;
      mon_locked_q <= mon_locked_d;
      err_stb_q    <= err_stb_d;
      err_flags_q  <= err_flags_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign mon_locked = mon_locked_q;
  assign err_stb    = err_stb_q;
  assign err_flags  = err_flags_q;
  assign err_cnt    = err_cnt_q;
  assign phase      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_amiga_clk_mon.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_amiga_clk_mon                                           |
// | Description : Directed self-checking bench for amiga_clk_mon. An ideal   |
// |               waveform generator drives the checker; faults are planted  |
// |               one at a time. A second instance with ERR_CNT_W=4 shares   |
// |               the stimulus to observe counter saturation.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_amiga_clk_mon;

  logic       clk_28   = 1'b0;
  logic       rst_n    = 1'b0;
  logic       clk7_en  = 1'b0;
  logic       clk7n_en = 1'b0;
  logic       c1       = 1'b0;
  logic       c3       = 1'b0;
  logic       eclk0    = 1'b0;
  logic       clr      = 1'b0;

  logic       mon_locked, err_stb;
  logic [3:0] err_flags;
  logic [7:0] err_cnt;
  logic [1:0] phase;

  logic       mon_locked4, err_stb4;
  logic [3:0] err_flags4;
  logic [3:0] err_cnt4;
  logic [1:0] phase4;

  int errors  = 0;
  int checks  = 0;
  int stb_cnt = 0;
  int g       = 0;
  int eg      = 0;
  int eperiod = 40;
  bit clk_run = 1'b1;

  amiga_clk_mon #(.LOCK_PERIODS(4), .ERR_CNT_W(8)) dut (
    .clk_28(clk_28), .rst_n(rst_n), .clk7_en(clk7_en), .clk7n_en(clk7n_en),
    .c1(c1), .c3(c3), .eclk0(eclk0), .clr(clr),
    .mon_locked(mon_locked), .err_stb(err_stb), .err_flags(err_flags),
    .err_cnt(err_cnt), .phase(phase)
  );

  amiga_clk_mon #(.LOCK_PERIODS(4), .ERR_CNT_W(4)) dut4 (
    .clk_28(clk_28), .rst_n(rst_n), .clk7_en(clk7_en), .clk7n_en(clk7n_en),
    .c1(c1), .c3(c3), .eclk0(eclk0), .clr(clr),
    .mon_locked(mon_locked4), .err_stb(err_stb4), .err_flags(err_flags4),
    .err_cnt(err_cnt4), .phase(phase4)
  );

  always begin
    #5;
    if (clk_run) clk_28 = ~clk_28;
  end

  // One 28 MHz cycle of the generator; optional missing clk7_en / flipped c3
  task automatic tick(input bit kill, input bit flip_c3);
    clk7_en  = (g == 0) && !kill;
    clk7n_en = (g == 2);
    c1       = (g == 1) || (g == 2);
    c3       = ((g == 2) || (g == 3)) ^ flip_c3;
    eclk0    = (eg < 4);
    if (clk7_en && mon_locked) begin
      checks++;
      if (phase !== 2'd0) begin
        errors++;
        $display("FAIL phase_on_clk7_en: got %0d want 0", phase);
      end
    end
    @(posedge clk_28);
    #1;
    g  = (g + 1) % 4;
    eg = (eg >= eperiod - 1) ? 0 : eg + 1;
    if (err_stb) stb_cnt++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  task automatic to_g(input int v);
    while (g != v) tick(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    clr   = 1'b0;
    rst_n = 1'b0;
    g     = 0;
    eg    = 0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mon_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", mon_locked); end
    checks++; if (err_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", err_stb); end
    checks++; if (err_flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", err_flags); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", err_cnt); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d want 0", phase); end
  endtask

  task automatic test_lock();
    int s;
    ticks(16);
    checks++; if (mon_locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0", mon_locked); end
    ticks(1);
    checks++; if (mon_locked !== 1'b1) begin errors++; $display("FAIL lock_time: got %b want 1", mon_locked); end
    s = stb_cnt;
    ticks(10000);
    checks++; if (err_flags !== 4'b0000) begin errors++; $display("FAIL lock_flags: got %b want 0000", err_flags); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL lock_cnt: got %0d want 0", err_cnt); end
    checks++; if (stb_cnt - s !== 0) begin errors++; $display("FAIL lock_stb: got %0d want 0", stb_cnt - s); end
    checks++; if (mon_locked !== 1'b1) begin errors++; $display("FAIL lock_hold: got %b want 1", mon_locked); end
  endtask

  task automatic test_missed_en();
    int s;
    to_g(0);
    s = stb_cnt;
    tick(1'b1, 1'b0);
    checks++; if (err_stb !== 1'b1) begin errors++; $display("FAIL miss_stb: got %b want 1", err_stb); end
    checks++; if (mon_locked !== 1'b0) begin errors++; $display("FAIL miss_unlock: got %b want 0", mon_locked); end
    checks++; if (err_flags !== 4'b0001) begin errors++; $display("FAIL miss_flags: got %b want 0001", err_flags); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL miss_cnt: got %0d want 1", err_cnt); end
    ticks(15);
    checks++; if (mon_locked !== 1'b0) begin errors++; $display("FAIL miss_relock_early: got %b want 0", mon_locked); end
    ticks(1);
    checks++; if (mon_locked !== 1'b1) begin errors++; $display("FAIL miss_relock: got %b want 1", mon_locked); end
    checks++; if (stb_cnt - s !== 1) begin errors++; $display("FAIL miss_stb_count: got %0d want 1", stb_cnt - s); end
    clr = 1'b1;
    ticks(1);
    clr = 1'b0;
    checks++; if (err_flags !== 4'b0000) begin errors++; $display("FAIL clr_flags: got %b want 0000", err_flags); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_c3_glitch();
    int s;
    to_g(1);
    s = stb_cnt;
    tick(1'b0, 1'b1);
    checks++; if (err_flags !== 4'b0100) begin errors++; $display("FAIL c3_flags: got %b want 0100", err_flags); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL c3_cnt: got %0d want 1", err_cnt); end
    checks++; if (err_stb !== 1'b1) begin errors++; $display("FAIL c3_stb: got %b want 1", err_stb); end
    checks++; if (mon_locked !== 1'b0) begin errors++; $display("FAIL c3_unlock: got %b want 0", mon_locked); end
    ticks(14);
    checks++; if (mon_locked !== 1'b0) begin errors++; $display("FAIL c3_relock_early: got %b want 0", mon_locked); end
    ticks(1);
    checks++; if (mon_locked !== 1'b1) begin errors++; $display("FAIL c3_relock: got %b want 1", mon_locked); end
    checks++; if (stb_cnt - s !== 1) begin errors++; $display("FAIL c3_stb_count: got %0d want 1", stb_cnt - s); end
    clr = 1'b1;
    ticks(1);
    clr = 1'b0;
  endtask

  task automatic test_c3_acq();
    int s;
    do_reset();
    s = stb_cnt;
    ticks(9);
    tick(1'b0, 1'b1);
    ticks(14);
    checks++; if (mon_locked !== 1'b0) begin errors++; $display("FAIL acq_lock_early: got %b want 0", mon_locked); end
    ticks(1);
    checks++; if (mon_locked !== 1'b1) begin errors++; $display("FAIL acq_lock: got %b want 1", mon_locked); end
    checks++; if (err_flags !== 4'b0000) begin errors++; $display("FAIL acq_flags: got %b want 0000", err_flags); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL acq_cnt: got %0d want 0", err_cnt); end
    checks++; if (stb_cnt - s !== 0) begin errors++; $display("FAIL acq_stb: got %0d want 0", stb_cnt - s); end
  endtask

  task automatic test_eclk();
    eperiod = 36;
    ticks(100);
`ifdef MINIMIG_CLK_MON_ECLK_EN
    checks++; if (err_flags !== 4'b1000) begin errors++; $display("FAIL eclk_flags: got %b want 1000", err_flags); end
    checks++; if (err_cnt == 8'd0) begin errors++; $display("FAIL eclk_cnt: got %0d want >=1", err_cnt); end
`else
    checks++; if (err_flags !== 4'b0000) begin errors++; $display("FAIL eclk_flags: got %b want 0000", err_flags); end
    checks++; if (mon_locked !== 1'b1) begin errors++; $display("FAIL eclk_locked: got %b want 1", mon_locked); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL eclk_cnt: got %0d want 0", err_cnt); end
`endif
    eperiod = 40;
  endtask

  task automatic test_back_to_back();
    int s;
    do_reset();
    ticks(17);
    checks++; if (mon_locked !== 1'b1) begin errors++; $display("FAIL b2b_lock: got %b want 1", mon_locked); end
    s = stb_cnt;
    for (int i = 0; i < 20; i++) begin
      to_g(0);
      tick(1'b1, 1'b0);
      ticks(16);
    end
    checks++; if (err_cnt !== 8'd20) begin errors++; $display("FAIL b2b_cnt8: got %0d want 20", err_cnt); end
    checks++; if (err_cnt4 !== 4'd15) begin errors++; $display("FAIL b2b_cnt4_sat: got %0d want 15", err_cnt4); end
    checks++; if (err_flags !== 4'b0001) begin errors++; $display("FAIL b2b_flags: got %b want 0001", err_flags); end
    checks++; if (err_flags4 !== 4'b0001) begin errors++; $display("FAIL b2b_flags4: got %b want 0001", err_flags4); end
    checks++; if (mon_locked !== 1'b1) begin errors++; $display("FAIL b2b_locked: got %b want 1", mon_locked); end
    checks++; if (stb_cnt - s !== 20) begin errors++; $display("FAIL b2b_stb_count: got %0d want 20", stb_cnt - s); end
    to_g(1);
    clr = 1'b1;
    tick(1'b0, 1'b1);
    clr = 1'b0;
    checks++; if (err_flags !== 4'b0100) begin errors++; $display("FAIL clr_err_flags: got %b want 0100", err_flags); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL clr_err_cnt: got %0d want 1", err_cnt); end
    checks++; if (err_cnt4 !== 4'd1) begin errors++; $display("FAIL clr_err_cnt4: got %0d want 1", err_cnt4); end
    checks++; if (err_stb !== 1'b1) begin errors++; $display("FAIL clr_err_stb: got %b want 1", err_stb); end
    ticks(15);
    checks++; if (mon_locked !== 1'b1) begin errors++; $display("FAIL clr_err_relock: got %b want 1", mon_locked); end
  endtask

  task automatic test_async_reset();
    clk_run = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (mon_locked !== 1'b0) begin errors++; $display("FAIL areset_locked: got %b want 0", mon_locked); end
    checks++; if (err_stb !== 1'b0) begin errors++; $display("FAIL areset_stb: got %b want 0", err_stb); end
    checks++; if (err_flags !== 4'b0000) begin errors++; $display("FAIL areset_flags: got %b want 0000", err_flags); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL areset_cnt: got %0d want 0", err_cnt); end
    checks++; if (err_cnt4 !== 4'd0) begin errors++; $display("FAIL areset_cnt4: got %0d want 0", err_cnt4); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL areset_phase: got %0d want 0", phase); end
    #3;
    g     = 0;
    eg    = 0;
    rst_n = 1'b1;
    clk_run = 1'b1;
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL arel_phase: got %0d want 0", phase); end
    ticks(16);
    checks++; if (mon_locked !== 1'b0) begin errors++; $display("FAIL arel_lock_early: got %b want 0", mon_locked); end
    ticks(1);
    checks++; if (mon_locked !== 1'b1) begin errors++; $display("FAIL arel_lock: got %b want 1", mon_locked); end
  endtask

  initial begin
    #7;
    test_reset();
    test_lock();
    test_missed_en();
    test_c3_glitch();
    test_c3_acq();
    test_eclk();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
